// File: rtl/aurora_tx_striper_if.sv
// AXI-stream beat interface between the user source and the Aurora TX striper.
// The master drives the beat; the slave (striper) returns ready.
interface aurora_tx_striper_if #(
  parameter int LANES = 4
);
  logic                  axi_valid;
  logic                  axi_ready;
  logic [LANES-1:0]      axi_keep;
  logic                  axi_last;
  logic [LANES*64-1:0]   axi_data;

  modport master (output axi_valid, axi_keep, axi_last, axi_data, input axi_ready);
  modport slave  (input axi_valid, axi_keep, axi_last, axi_data, output axi_ready);
endinterface

// File: rtl/aurora_tx_striper.sv
// Multi-lane Aurora 64b/66b simplex TX framer/striper: channel init FSM plus lane striping.
// Optional payload scrambling is enabled by defining AURORA_SCRAMBLER_EN.
module aurora_tx_striper #(
  parameter int LANES         = 4,
  parameter int DATA_W        = 64,
  parameter int RESET_CYCLES  = 4,
  parameter int ALIGN_CYCLES  = 16,
  parameter int BOND_CYCLES   = 8,
  parameter int VERIFY_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        reinit,
  input  logic [3:0]                  lane_count,
  aurora_tx_striper_if.slave          axi,
  output logic                        simplex_reset,
  output logic                        simplex_aligned,
  output logic                        simplex_bonded,
  output logic                        simplex_verified,
  output logic [LANES*(DATA_W+2)-1:0] data_out
);

  localparam int BLK_W = DATA_W + 2;
  localparam logic [BLK_W-1:0] BLK_IDLE   = {2'b10, 8'h78, {(DATA_W-8){1'b0}}};
  localparam logic [BLK_W-1:0] BLK_VERIFY = {2'b10, 8'h78, 8'hA5, {(DATA_W-16){1'b0}}};
  localparam logic [BLK_W-1:0] BLK_SEP    = {2'b10, 8'h1E, {(DATA_W-8){1'b0}}};

  typedef enum logic [2:0] {ST_RESET, ST_ALIGN, ST_BOND, ST_VERIFY, ST_READY} state_t;

  state_t                        state;
  state_t                        next_state;
  logic [15:0]                   cnt;
  logic [3:0]                    act;
  logic [3:0]                    lane_clamped;
  logic                          sep_pending;
  logic                          set_pending;
  logic                          accept;
  logic [LANES-1:0][BLK_W-1:0]   blk_next;
  logic [LANES-1:0][BLK_W-1:0]   blk_emit;

  assign lane_clamped = (lane_count == 4'd0 || int'(lane_count) > LANES) ? 4'd1 : lane_count;
  assign accept       = axi.axi_valid && axi.axi_ready && !reinit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      cnt   <= (next_state != state || reinit || state == ST_READY) ? 16'd0 : cnt + 16'd1;
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_RESET:  if (cnt == 16'(RESET_CYCLES - 1))  next_state = ST_ALIGN;
      ST_ALIGN:  if (cnt == 16'(ALIGN_CYCLES - 1))  next_state = ST_BOND;
      ST_BOND:   if (cnt == 16'(BOND_CYCLES - 1))   next_state = ST_VERIFY;
      ST_VERIFY: if (cnt == 16'(VERIFY_CYCLES - 1)) next_state = ST_READY;
      default:   next_state = ST_READY;
    endcase
    if (reinit) next_state = ST_RESET;
  end

  always_comb begin
    simplex_reset    = (state == ST_RESET);
    simplex_aligned  = (state == ST_BOND) || (state == ST_VERIFY) || (state == ST_READY);
    simplex_bonded   = (state == ST_VERIFY) || (state == ST_READY);
    simplex_verified = (state == ST_READY);
    axi.axi_ready    = (state == ST_READY) && !sep_pending;
  end

  // Blocks are built from the upcoming state so data_out lines up with the state it belongs to.
  // 'run' tracks the keep prefix; the first hole on a last beat carries the separator.
  always_comb begin : build_blocks
    logic run;
    run = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      blk_next[i] = BLK_IDLE;
      if (i < int'(act)) begin
        if (next_state == ST_VERIFY) begin
          blk_next[i] = BLK_VERIFY;
        end else if (next_state == ST_READY) begin
          if (sep_pending) begin
            if (i == 0) blk_next[i] = BLK_SEP;
          end else if (accept) begin
            if (run && axi.axi_keep[i]) begin
              blk_next[i] = {2'b01, axi.axi_data[i*DATA_W +: DATA_W]};
            end else begin
              if (run && axi.axi_last) blk_next[i] = BLK_SEP;
              run = 1'b0;
            end
          end
        end
      end
    end
    set_pending = accept && axi.axi_last && run;
  end

`ifdef AURORA_SCRAMBLER_EN
  logic [LANES-1:0][57:0] scr_state;
  logic [LANES-1:0][57:0] scr_next;

  // Self-synchronizing x^58+x^39+1, payload LSB first; every emitted block advances it.
  always_comb begin : scramble
    logic [57:0] s;
    logic        o;
    blk_emit = blk_next;
    scr_next = scr_state;
    s        = '0;
    o        = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      s = scr_state[i];
      for (int b = 0; b < DATA_W; b++) begin
        o              = blk_next[i][b] ^ s[38] ^ s[57];
        blk_emit[i][b] = o;
        s              = {s[56:0], o};
      end
      scr_next[i] = s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || reinit) scr_state <= '1;
    else                  scr_state <= scr_next;
  end
`else
  assign blk_emit = blk_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sep_pending <= 1'b0;
      act         <= 4'd1;
      data_out    <= {LANES{BLK_IDLE}};
    end else begin
      sep_pending <= set_pending;
      if (state == ST_RESET) act <= lane_clamped;
      data_out    <= blk_emit;
    end
  end

endmodule

// File: tb/tb_aurora_tx_striper.sv
// Self-checking bench for aurora_tx_striper: directed scenarios plus randomized traffic
// checked against a cycle-count based behavioural model of the channel.
module tb_aurora_tx_striper;
  localparam int LANES  = 4;
  localparam int R_DONE = 4;
  localparam int A_DONE = 20;
  localparam int B_DONE = 28;
  localparam int V_DONE = 36;
  localparam logic [65:0] IDLE   = {2'b10, 8'h78, 56'h0};
  localparam logic [65:0] VERIFY = {2'b10, 8'h78, 8'hA5, 48'h0};
  localparam logic [65:0] SEP    = {2'b10, 8'h1E, 56'h0};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  reinit;
  logic [3:0]            lane_count;
  logic                  simplex_reset, simplex_aligned, simplex_bonded, simplex_verified;
  logic [LANES*66-1:0]   data_out;
  logic [4:0]            stat;

  aurora_tx_striper_if #(.LANES(LANES)) bus ();

  aurora_tx_striper #(.LANES(LANES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reinit           (reinit),
    .lane_count       (lane_count),
    .axi              (bus.slave),
    .simplex_reset    (simplex_reset),
    .simplex_aligned  (simplex_aligned),
    .simplex_bonded   (simplex_bonded),
    .simplex_verified (simplex_verified),
    .data_out         (data_out)
  );

  always #5 clk = ~clk;

  assign stat = {simplex_reset, simplex_aligned, simplex_bonded, simplex_verified, bus.axi_ready};

  int                  total = 0;
  int                  bad   = 0;
  int                  m_t;
  int                  m_act;
  logic                m_pend;
  logic [LANES*66-1:0] m_flat;

  // Expected status in the current cycle: purely from cycles elapsed since init start.
  function automatic logic [4:0] exp_stat();
    return {m_t < R_DONE, m_t >= A_DONE, m_t >= B_DONE, m_t >= V_DONE,
            (m_t >= V_DONE) && !m_pend};
  endfunction

  // Advance the model by one clock given the inputs currently driven.
  task automatic model_step();
    logic acc;
    int   n;
    acc = bus.axi_valid && (m_t >= V_DONE) && !m_pend && !reinit;
    m_flat = {LANES{IDLE}};
    if (reinit) begin
      m_t    = 0;
      m_pend = 1'b0;
    end else begin
      if (m_t < R_DONE)
        m_act = (lane_count == 4'd0 || int'(lane_count) > LANES) ? 1 : int'(lane_count);
      if (m_t + 1 >= B_DONE && m_t + 1 < V_DONE) begin
        for (int i = 0; i < m_act; i++) m_flat[i*66 +: 66] = VERIFY;
      end else if (m_pend) begin
        m_flat[65:0] = SEP;
        m_pend       = 1'b0;
      end else if (acc) begin
        n = 0;
        while (n < m_act && bus.axi_keep[n]) n++;
        for (int i = 0; i < n; i++) m_flat[i*66 +: 66] = {2'b01, bus.axi_data[i*64 +: 64]};
        if (bus.axi_last) begin
          if (n < m_act) m_flat[n*66 +: 66] = SEP;
          else           m_pend = 1'b1;
        end
      end
      m_t++;
    end
  endtask

  task automatic tick(input logic v, input logic [LANES-1:0] k, input logic l,
                      input logic [LANES*64-1:0] d, input logic ri);
    bus.axi_valid = v;
    bus.axi_keep  = k;
    bus.axi_last  = l;
    bus.axi_data  = d;
    reinit        = ri;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] lc);
    rst_n         = 1'b0;
    reinit        = 1'b0;
    lane_count    = lc;
    bus.axi_valid = 1'b0;
    bus.axi_keep  = '0;
    bus.axi_last  = 1'b0;
    bus.axi_data  = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    m_t    = 0;
    m_act  = 1;
    m_pend = 1'b0;
    m_flat = {LANES{IDLE}};
  endtask

  function automatic logic [LANES-1:0] rand_keep();
    int n;
    n = $urandom_range(0, LANES);
    if ($urandom_range(0, 3) != 0) return LANES'((1 << n) - 1);
    return LANES'($urandom);
  endfunction

  function automatic logic [LANES*64-1:0] rand_data();
    logic [LANES*64-1:0] d;
    for (int j = 0; j < LANES * 2; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic test_reset();
    do_reset(4'd4);
    total++;
    if (stat !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_stat got=%b exp=%b", stat, 5'b10000);
    end
    total++;
    if (data_out !== {LANES{IDLE}}) begin
      bad++;
      $display("[TB] FAIL reset_data got=%h exp=%h", data_out, {LANES{IDLE}});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    do_reset(4'd4);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      total++;
      if (stat !== exp_stat()) begin
        bad++;
        $display("[TB] FAIL init_stat t=%0d got=%b exp=%b", m_t, stat, exp_stat());
      end
      total++;
      if (data_out !== m_flat) begin
        bad++;
        $display("[TB] FAIL init_data t=%0d got=%h exp=%h", m_t, data_out, m_flat);
      end
      if (m_t == A_DONE) begin
        total++;
        if ({simplex_aligned, simplex_bonded} !== 2'b10) begin
          bad++;
          $display("[TB] FAIL init_aligned t=%0d got=%b exp=10", m_t, {simplex_aligned, simplex_bonded});
        end
      end
      if (m_t >= B_DONE && m_t < V_DONE) begin
        total++;
        if (data_out[LANES*66-1 -: 66] !== VERIFY) begin
          bad++;
          $display("[TB] FAIL init_verify t=%0d got=%h exp=%h", m_t, data_out[LANES*66-1 -: 66], VERIFY);
        end
      end
      if (m_t == V_DONE) begin
        total++;
        if (bus.axi_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL init_ready t=%0d got=%b exp=1", m_t, bus.axi_ready);
        end
      end
      tick(1'b0, '0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_full_beat();
    tick(1'b1, 4'b1111, 1'b0, {64'h4, 64'h3, 64'h2, 64'h1}, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      total++;
      if (data_out[i*66 +: 66] !== {2'b01, 64'(i + 1)}) begin
        bad++;
        $display("[TB] FAIL full_beat_lane%0d got=%h exp=%h", i, data_out[i*66 +: 66], {2'b01, 64'(i + 1)});
      end
    end
    total++;
    if (bus.axi_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_beat_ready got=%b exp=1", bus.axi_ready);
    end
  endtask

  task automatic test_partial_last();
    tick(1'b1, 4'b0011, 1'b1, rand_data(), 1'b0);
    total++;
    if (data_out !== m_flat) begin
      bad++;
      $display("[TB] FAIL partial_data got=%h exp=%h", data_out, m_flat);
    end
    total++;
    if (data_out[2*66 +: 66] !== SEP || data_out[3*66 +: 66] !== IDLE || data_out[65:64] !== 2'b01) begin
      bad++;
      $display("[TB] FAIL partial_sep got=%h exp_lane2=%h", data_out[2*66 +: 66], SEP);
    end
  endtask

  task automatic test_two_lane();
    do_reset(4'd2);
    rst_n = 1'b1;
    repeat (V_DONE) tick(1'b0, '0, 1'b0, '0, 1'b0);
    tick(1'b1, 4'b1111, 1'b1, rand_data(), 1'b0);
    total++;
    if (data_out !== m_flat || data_out[65:64] !== 2'b01 || data_out[131:130] !== 2'b01
        || data_out[LANES*66-1:132] !== {2{IDLE}}) begin
      bad++;
      $display("[TB] FAIL two_lane_data got=%h exp=%h", data_out, m_flat);
    end
    total++;
    if (bus.axi_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL two_lane_pending_ready got=%b exp=0", bus.axi_ready);
    end
    tick(1'b1, 4'b1111, 1'b0, rand_data(), 1'b0);
    total++;
    if (data_out !== {{3{IDLE}}, SEP}) begin
      bad++;
      $display("[TB] FAIL two_lane_sep got=%h exp=%h", data_out, {{3{IDLE}}, SEP});
    end
    total++;
    if (stat !== exp_stat() || bus.axi_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL two_lane_ready_back got=%b exp=%b", stat, exp_stat());
    end
    tick(1'b0, '0, 1'b0, '0, 1'b0);
    total++;
    if (data_out !== {LANES{IDLE}}) begin
      bad++;
      $display("[TB] FAIL two_lane_dropped_beat got=%h exp=%h", data_out, {LANES{IDLE}});
    end
  endtask

  task automatic test_reinit();
    lane_count = 4'd4;
    tick(1'b1, 4'b1111, 1'b1, rand_data(), 1'b1);
    total++;
    if (stat !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reinit_stat got=%b exp=10000", stat);
    end
    total++;
    if (data_out !== {LANES{IDLE}}) begin
      bad++;
      $display("[TB] FAIL reinit_data got=%h exp=%h", data_out, {LANES{IDLE}});
    end
    for (int c = 0; c < V_DONE; c++) begin
      total++;
      if (stat !== exp_stat() || data_out !== m_flat) begin
        bad++;
        $display("[TB] FAIL reinit_seq t=%0d got=%b/%h exp=%b/%h", m_t, stat, data_out, exp_stat(), m_flat);
      end
      tick(1'b0, '0, 1'b0, '0, 1'b0);
    end
    tick(1'b1, 4'b1111, 1'b1, rand_data(), 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    total++;
    if (data_out !== {LANES{IDLE}} || stat !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reinit_no_sep got=%b/%h exp=10000/%h", stat, data_out, {LANES{IDLE}});
    end
  endtask

  task automatic test_single_lane();
    do_reset(4'd0);
    rst_n = 1'b1;
    repeat (V_DONE) tick(1'b0, '0, 1'b0, '0, 1'b0);
    for (int c = 0; c < 30; c++) begin
      tick($urandom_range(0, 3) != 0, rand_keep(), $urandom_range(0, 2) == 0, rand_data(), 1'b0);
      total++;
      if (data_out !== m_flat || stat !== exp_stat()) begin
        bad++;
        $display("[TB] FAIL single_lane t=%0d got=%b/%h exp=%b/%h", m_t, stat, data_out, exp_stat(), m_flat);
      end
      total++;
      if (data_out[LANES*66-1:66] !== {(LANES-1){IDLE}}) begin
        bad++;
        $display("[TB] FAIL single_lane_upper got=%h exp=%h", data_out[LANES*66-1:66], {(LANES-1){IDLE}});
      end
    end
  endtask

  task automatic test_random(input int cycles, input logic [3:0] lc);
    do_reset(lc);
    rst_n = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 15) == 0) lane_count = 4'($urandom);
      tick($urandom_range(0, 3) != 0, rand_keep(), $urandom_range(0, 2) == 0, rand_data(),
           $urandom_range(0, 199) == 0);
      total++;
      if (stat !== exp_stat()) begin
        bad++;
        $display("[TB] FAIL random_stat t=%0d got=%b exp=%b", m_t, stat, exp_stat());
      end
      total++;
      if (data_out !== m_flat) begin
        bad++;
        $display("[TB] FAIL random_data t=%0d got=%h exp=%h", m_t, data_out, m_flat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_full_beat();
    test_partial_last();
    test_two_lane();
    test_reinit();
    test_single_lane();
    for (int r = 0; r < 4; r++) test_random(250, 4'($urandom_range(0, 9)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aurora_tx_striper.md
Name: aurora_tx_striper

Overview:
- Multi-lane Aurora 64b/66b simplex TX framer/striper; next generation of the single/dual-lane TX path.
- Runs the simplex channel-init sequence (reset, align, bond, verify, ready) from internal timers.
- Stripes a wide AXI-stream beat across 1..LANES lanes and emits one registered 66-bit block per lane per cycle.
- Sits between the user AXI-stream source and the per-lane serializers.

Parameters:
LANES, 4, number of physical lanes (1..8)
DATA_W, 64, block payload width per lane (fixed 64; block width DATA_W+2)
RESET_CYCLES, 4, cycles spent in ST_RESET
ALIGN_CYCLES, 16, cycles spent in ST_ALIGN
BOND_CYCLES, 8, cycles spent in ST_BOND
VERIFY_CYCLES, 8, cycles spent in ST_VERIFY

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
reinit  in  1  pulse; restart channel init from ST_RESET
lane_count  in  4  active lanes 0..lane_count-1; sampled only in ST_RESET
axi_valid  in  1  beat valid
axi_ready  out  1  beat accepted when valid&ready
axi_keep  in  LANES  per-lane word valid, thermometer from lane 0
axi_last  in  1  final beat of frame
axi_data  in  LANES*64  lane i word = axi_data[i*64+:64]
simplex_reset  out  1  high in ST_RESET
simplex_aligned  out  1  ALIGN completed
simplex_bonded  out  1  BOND completed
simplex_verified  out  1  VERIFY completed
data_out  out  LANES*66  lane i block = data_out[i*66+:66], header in [65:64]

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=ST_RESET, counter=0, axi_ready=0.
  - simplex_reset=1; other status flags 0.
  - Every lane data_out=IDLE.
  - Pending separator cleared.
  - Sampled lane count=1.
- Block formats (header, then 64-bit payload):
  - DATA = {2'b01, word}
  - IDLE = {2'b10, 8'h78, 56'h0}
  - VERIFY = {2'b10, 8'h78, 8'hA5, 48'h0}
  - SEP = {2'b10, 8'h1E, 56'h0}
- FSM:
  - ST_RESET: RESET_CYCLES cycles, all lanes IDLE, latch lane_count. Value 0 or >LANES clamps to 1.
  - ST_ALIGN: ALIGN_CYCLES cycles, IDLE.
  - ST_BOND: BOND_CYCLES cycles, IDLE.
  - ST_VERIFY: VERIFY_CYCLES cycles, VERIFY on active lanes.
  - ST_READY: user traffic.
  - Each status flag rises on the cycle the FSM leaves the corresponding state and stays high until the next reset/reinit. simplex_reset falls on entry to ST_ALIGN.
- reinit=1 in any state: next cycle state=ST_RESET and all outputs take reset values. Wins over a simultaneous beat; that beat is not accepted.
- axi_ready=1 only in ST_READY with no pending separator.
- Latency: accepted beat appears on data_out on the next cycle.
- Lanes >= active count always emit IDLE.
- Accepted beat, per active lane i:
  - keep[i]=1 -> DATA(word i).
  - keep[i]=0 -> IDLE, except the first unused lane of a last beat -> SEP.
  - last beat with all active lanes kept -> SEP pending. Next cycle: lane 0 emits SEP, other active lanes IDLE, axi_ready=0 during that cycle.
- No accepted beat in ST_READY -> all lanes IDLE.
- Beat with keep=0 and last=1 -> SEP on lane 0, rest IDLE.
- keep bits at or above the active count are ignored.
- Non-thermometer keep is a protocol violation: words at lanes above the first 0 are dropped and emitted as IDLE.
- lane_count changes outside ST_RESET have no effect.
- Reset mid-frame: the partial frame is discarded and no SEP is emitted.

Optional Feature:
AURORA_SCRAMBLER_EN:
- Defined: each lane scrambles its 64-bit payload (headers untouched) with a self-synchronizing x^58+x^39+1 scrambler, LSB first.
- Per-lane 58-bit state is reset to all ones by rst_n/reinit and advances on every emitted block, including IDLE.
- Undefined: payload is emitted unscrambled, with no scrambler logic.

Test Plan:
- Reset 2 cycles, then run -> simplex_reset high 4 cycles; aligned at cycle 20, bonded at 28, verified at 36 after reset release; axi_ready=1 from cycle 36; lanes IDLE during init, VERIFY during cycles 28-35.
- lane_count=4; beat keep=4'b1111 data lanes 0..3 = 64'h1..64'h4, last=0 -> next cycle four DATA blocks with header 2'b01 and words 1..4.
- lane_count=4; beat keep=4'b0011 last=1 -> lanes 0,1 DATA; lane 2 SEP (payload MSB byte 8'h1E); lane 3 IDLE.
- lane_count=2; beat keep=2'b11 last=1 -> DATA,DATA; next cycle axi_ready=0, lane 0 SEP, lane 1 IDLE, lanes 2,3 IDLE throughout.
- reinit pulsed while axi_valid=1 in ST_READY -> beat not accepted; next cycle simplex_reset=1, all flags 0, all lanes IDLE; full init sequence repeats.
- lane_count=0 latched at reset -> single-lane operation: only lane 0 carries DATA/SEP, other lanes constant IDLE.
